aes_core_arbiter: RTL and testbench
===================================

// Module: aes_core_arbiter
// PURPOSE
//  Shares one aes_core between NUM_REQ requesters. Each requester presents a job: key, keylen,
//  encdec and block. Grants are round-robin. The arbiter sequences the core's init (key expansion)
//  and next (block) pulses, holds core inputs stable, and returns the result to the granted
//  requester over a valid/ready response. Sits between bus/DMA requesters and the aes_core instance.
// PARAMETERS
//  NUM_REQ   default 2   requester count, legal range 2..4
//  REQ_W     derived     clog2(NUM_REQ), width of the grant index (local, not overridable)
// PORTS
//  clk                input   1            system clock
//  reset_n            input   1            reset, synchronous, active-low
//  req_valid          input   NUM_REQ      job pending, one bit per requester
//  req_ready          output  NUM_REQ      job accepted this cycle (one-hot or zero)
//  req_encdec         input   NUM_REQ      1=encipher, 0=decipher
//  req_keylen         input   NUM_REQ      0=128-bit, 1=256-bit key
//  req_key            input   NUM_REQ*256  packed keys; requester i at [i*256 +: 256]
//  req_block          input   NUM_REQ*128  packed blocks; requester i at [i*128 +: 128]
//  rsp_valid          output  NUM_REQ      result valid for requester i (one-hot or zero)
//  rsp_ready          input   NUM_REQ      requester i takes the result
//  rsp_result         output  128          result, shared by all requesters
//  core_init          output  1            to aes_core.init
//  core_next          output  1            to aes_core.next
//  core_encdec        output  1            to aes_core.encdec
//  core_keylen        output  1            to aes_core.keylen
//  core_key           output  256          to aes_core.key
//  core_block         output  128          to aes_core.block
//  core_ready         input   1            from aes_core.ready
//  core_result        input   128          from aes_core.result
//  core_result_valid  input   1            from aes_core.result_valid
// BEHAVIOUR
//  - Reset: when reset_n is low at a clk edge, all of the following take effect.
//    - State returns to IDLE; an in-flight job is dropped and no response is issued.
//    - last_grant resets to NUM_REQ-1, so requester 0 wins first.
//    - key_loaded resets to 0.
//    - Job and result registers reset to 0.
//    - req_ready, rsp_valid, core_init and core_next are 0 while reset_n is low.
//  - FSM states: IDLE, INIT, INIT_WAIT, NEXT, NEXT_WAIT, RESP.
//  - IDLE:
//    - If core_ready=1 and any req_valid is set: grant g = first set bit searching upward
//      from last_grant+1, wrapping modulo NUM_REQ.
//    - req_ready[g]=1 combinationally in that cycle; at the edge, capture encdec, keylen, key
//      and block into job registers, and set owner=g.
//    - Next state is INIT if a key load is needed (see CONFIGURATION), else NEXT.
//    - No grant is issued if core_ready=0.
//  - INIT: core_init=1 for exactly 1 cycle. Next state is INIT_WAIT.
//  - INIT_WAIT: wait for core_ready=1, then set key_loaded=1, store the loaded key/keylen,
//    and go to NEXT.
//  - NEXT: core_next=1 for exactly 1 cycle. Next state is NEXT_WAIT.
//  - NEXT_WAIT: wait for core_ready=1 and core_result_valid=1, then register core_result
//    into rsp_result and go to RESP.
//  - RESP: rsp_valid[owner]=1, held with rsp_result stable until rsp_ready[owner]=1.
//    At that edge, last_grant=owner and the next state is IDLE. rsp_ready on other bits is ignored.
//  - core_key, core_keylen, core_encdec and core_block are driven from the job registers only,
//    and stay stable from capture until RESP exits. core_encdec must stay stable because the
//    core's result mux depends on it.
//  - core_init and core_next are never high in the same cycle.
//  - Latency from accept to rsp_valid: 2 + T_next + 1 cycles without key load, where T_next is
//    the number of cycles core_ready stays low. With key load, add 2 + T_init.
//  - Simultaneous events:
//    - A req_valid that drops before grant is not an error; only the grant cycle is sampled.
//    - req_valid for the owner during RESP is not accepted until IDLE; no back-to-back bypass.
//    - A requester with rsp_ready held high receives rsp_valid for exactly 1 cycle.
// CONFIGURATION
//  - Macro AES_ARB_KEY_CACHE_EN.
//  - Defined: IDLE goes to INIT only if key_loaded=0 or the captured {keylen,key} differs from
//    the stored loaded {keylen,key}. For keylen=0, only key[127:0] takes part in the compare.
//    Otherwise IDLE goes straight to NEXT.
//  - Undefined: every job goes through INIT. The loaded-key register and comparator are not
//    built; key_loaded is still kept for debug.
// TESTING
//  1 Reset: drive reset_n=0 for 2 clocks mid-NEXT_WAIT -> state=IDLE, rsp_valid=0, core_init=0,
//    core_next=0; the next job is granted normally.
//  2 Single job: requester 0, key=000102..1f (keylen=1), block=00112233..eeff, encdec=1
//    -> rsp_result=8ea2b7ca516745bfeafc49904b496089 on rsp_valid[0].
//    Repeat with encdec=0 on that ciphertext -> plaintext returns.
//  3 Round-robin: NUM_REQ=3, all req_valid held high -> grants 0,1,2,0,1,2. No requester is
//    granted twice while another is waiting.
//  4 Key cache (AES_ARB_KEY_CACHE_EN defined): two jobs with the same 128-bit key -> one
//    core_init pulse. Third job with a different key -> a second core_init.
//    Macro undefined -> three core_init pulses.
//  5 Backpressure: rsp_ready[1]=0 for 10 cycles -> rsp_valid[1] and rsp_result held stable;
//    req_ready stays 0 for all requesters until the handshake.
//  6 Core busy: core_ready forced 0 in IDLE with req_valid=1 -> no req_ready and no core_init
//    or core_next until core_ready=1.

Source files
------------

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one aes_core between NUM_REQ requesters (init/next sequencing, result return).
// Optional key cache enabled by defining AES_ARB_KEY_CACHE_EN: skips key expansion when the key is unchanged.
module aes_core_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_encdec,
  input  logic [NUM_REQ-1:0]     req_keylen,
  input  logic [NUM_REQ*256-1:0] req_key,
  input  logic [NUM_REQ*128-1:0] req_block,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [127:0]           rsp_result,
  output logic                   core_init,
  output logic                   core_next,
  output logic                   core_encdec,
  output logic                   core_keylen,
  output logic [255:0]           core_key,
  output logic [127:0]           core_block,
  input  logic                   core_ready,
  input  logic [127:0]           core_result,
  input  logic                   core_result_valid
);

  localparam int unsigned REQ_W = $clog2(NUM_REQ);
  localparam int unsigned KEY_W = 256;
  localparam int unsigned BLK_W = 128;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_INIT_WAIT, S_NEXT, S_NEXT_WAIT, S_RESP
  } state_e;

  typedef struct packed {
    logic             encdec;
    logic             keylen;
    logic [KEY_W-1:0] key;
    logic [BLK_W-1:0] block;
  } job_t;

  state_e             state_q;
  job_t               job_q;
  logic [REQ_W-1:0]   owner_q;
  logic [REQ_W-1:0]   last_grant_q;
  logic               key_loaded_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [BLK_W-1:0]   rsp_result_q;
  logic               core_init_q;
  logic               core_next_q;

  job_t               req_job_c [NUM_REQ];
  job_t               sel_job_c;
  logic               gnt_found_c;
  logic [REQ_W-1:0]   gnt_idx_c;
  logic               grant_c;
  logic               key_miss_c;
  logic               need_init_c;

  // Unpack the flat request buses into per-requester jobs.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_job_c[i].encdec = req_encdec[i];
      req_job_c[i].keylen = req_keylen[i];
      req_job_c[i].key    = req_key[i*KEY_W +: KEY_W];
      req_job_c[i].block  = req_block[i*BLK_W +: BLK_W];
    end
  end

  // Round-robin search starting just after the last served requester.
  always_comb begin
    logic [REQ_W-1:0] cand;
    cand        = '0;
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = REQ_W'((32'(last_grant_q) + k + 32'd1) % NUM_REQ);
      if (!gnt_found_c && req_valid[cand]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = cand;
      end
    end
  end

  assign sel_job_c   = req_job_c[gnt_idx_c];
  assign grant_c     = reset_n && (state_q == S_IDLE) && core_ready && gnt_found_c;
  assign req_ready   = grant_c ? (NUM_REQ'(1) << gnt_idx_c) : '0;

`ifdef AES_ARB_KEY_CACHE_EN
  logic             loaded_keylen_q;
  logic [KEY_W-1:0] loaded_key_q;

  // 128-bit keys compare on the low half only.
  function automatic logic [KEY_W-1:0] eff_key(input logic keylen, input logic [KEY_W-1:0] key);
    return keylen ? key : {{(KEY_W-BLK_W){1'b0}}, key[BLK_W-1:0]};
  endfunction

  assign key_miss_c = (sel_job_c.keylen != loaded_keylen_q) ||
                      (eff_key(sel_job_c.keylen, sel_job_c.key) != loaded_key_q);
`else
  assign key_miss_c = 1'b1;
`endif

  assign need_init_c = !key_loaded_q || key_miss_c;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      job_q        <= '0;
      owner_q      <= '0;
      last_grant_q <= REQ_W'(NUM_REQ - 1);
      key_loaded_q <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      core_init_q  <= 1'b0;
      core_next_q  <= 1'b0;
`ifdef AES_ARB_KEY_CACHE_EN
      loaded_keylen_q <= 1'b0;
      loaded_key_q    <= '0;
`endif
    end else begin
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_c) begin
            job_q   <= sel_job_c;
            owner_q <= gnt_idx_c;
            if (need_init_c) begin
              state_q     <= S_INIT;
              core_init_q <= 1'b1;
            end else begin
              state_q     <= S_NEXT;
              core_next_q <= 1'b1;
            end
          end
        end
        S_INIT: state_q <= S_INIT_WAIT;
        S_INIT_WAIT: begin
          if (core_ready) begin
            key_loaded_q <= 1'b1;
`ifdef AES_ARB_KEY_CACHE_EN
            loaded_keylen_q <= job_q.keylen;
            loaded_key_q    <= eff_key(job_q.keylen, job_q.key);
`endif
            state_q     <= S_NEXT;
            core_next_q <= 1'b1;
          end
        end
        S_NEXT: state_q <= S_NEXT_WAIT;
        S_NEXT_WAIT: begin
          if (core_ready && core_result_valid) begin
            rsp_result_q         <= core_result;
            rsp_valid_q[owner_q] <= 1'b1;
            state_q              <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready[owner_q]) begin
            rsp_valid_q  <= '0;
            last_grant_q <= owner_q;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pulses and response valid are forced low for as long as reset is held.
  assign rsp_valid   = rsp_valid_q & {NUM_REQ{reset_n}};
  assign core_init   = core_init_q & reset_n;
  assign core_next   = core_next_q & reset_n;
  assign rsp_result  = rsp_result_q;
  assign core_encdec = job_q.encdec;
  assign core_keylen = job_q.keylen;
  assign core_key    = job_q.key;
  assign core_block  = job_q.block;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: behavioural core stub, job-level reference model, directed and random jobs.
module tb_aes_core_arbiter;
  localparam int unsigned N = 3;
`ifdef AES_ARB_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid, req_ready, req_encdec, req_keylen, rsp_valid, rsp_ready;
  logic [N*256-1:0] req_key;
  logic [N*128-1:0] req_block;
  logic [127:0]   rsp_result, core_block, core_result;
  logic           core_init, core_next, core_encdec, core_keylen, core_ready, core_result_valid;
  logic [255:0]   core_key;

  int vectors = 0;
  int miscompares = 0;
  int init_cnt = 0;
  int next_cnt = 0;

  always #5 clk = ~clk;

  aes_core_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_encdec(req_encdec),
    .req_keylen(req_keylen), .req_key(req_key), .req_block(req_block),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .core_init(core_init), .core_next(core_next), .core_encdec(core_encdec),
    .core_keylen(core_keylen), .core_key(core_key), .core_block(core_block),
    .core_ready(core_ready), .core_result(core_result), .core_result_valid(core_result_valid)
  );

  // Core behaviour: real AES on the known vector, an invertible keyed mix elsewhere.
  function automatic logic [127:0] core_fn(input logic enc, input logic kl,
                                           input logic [255:0] key, input logic [127:0] blk);
    logic [127:0] k;
    if (kl && key == KAT_KEY && enc && blk == KAT_PT) return KAT_CT;
    if (kl && key == KAT_KEY && !enc && blk == KAT_CT) return KAT_PT;
    k = kl ? (key[255:128] ^ key[127:0]) : key[127:0];
    return enc ? ((blk ^ k) + 128'd1) : ((blk - 128'd1) ^ k);
  endfunction

  function automatic logic [255:0] eff(input logic kl, input logic [255:0] k);
    return kl ? k : {128'd0, k[127:0]};
  endfunction

  // aes_core stub: uses the key latched at the last init, busy for a random number of cycles.
  logic         s_ready, s_rv, s_op, s_kl;
  logic [255:0] s_key;
  logic [127:0] s_res, s_pend;
  int           s_cnt;
  bit           force_busy = 1'b0;
  int           lat_lo = 0, lat_hi = 4;
  assign core_ready        = s_ready & ~force_busy;
  assign core_result       = s_res;
  assign core_result_valid = s_rv;

  always @(posedge clk) begin
    if (!reset_n) begin
      s_ready <= 1'b1; s_rv <= 1'b0; s_op <= 1'b0; s_cnt <= 0;
      s_res <= '0; s_pend <= '0; s_key <= '0; s_kl <= 1'b0;
    end else if (core_init && s_ready) begin
      s_key <= core_key; s_kl <= core_keylen; s_ready <= 1'b0; s_op <= 1'b0;
      s_cnt <= $urandom_range(lat_hi, lat_lo);
    end else if (core_next && s_ready) begin
      s_pend <= core_fn(core_encdec, s_kl, s_key, core_block);
      s_ready <= 1'b0; s_rv <= 1'b0; s_op <= 1'b1;
      s_cnt <= $urandom_range(lat_hi, lat_lo);
    end else if (!s_ready) begin
      if (s_cnt == 0) begin
        s_ready <= 1'b1;
        if (s_op) begin s_rv <= 1'b1; s_res <= s_pend; end
      end else s_cnt <= s_cnt - 1;
    end
  end

  // Pulse protocol: init/next exclusive and only issued to an idle core.
  always @(posedge clk) begin
    if (reset_n && (core_init || core_next)) begin
      vectors++;
      assert (!(core_init && core_next) && core_ready === 1'b1) else begin
        miscompares++;
        $error("FAIL pulse_proto observed init=%0b next=%0b ready=%0b expected exclusive pulse to ready core",
               core_init, core_next, core_ready);
      end
      if (core_init) init_cnt++;
      if (core_next) next_cnt++;
    end
  end

  // Requester-side job table and reference model state.
  bit           pend [N];
  logic         j_enc [N], j_kl [N];
  logic [255:0] j_key [N];
  logic [127:0] j_blk [N];
  logic [255:0] key_pool [3];
  int           mlast;
  bit           mloaded;
  logic         mkl;
  logic [255:0] mkey;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      req_valid[i] = pend[i]; req_encdec[i] = j_enc[i]; req_keylen[i] = j_kl[i];
      req_key[i*256 +: 256] = j_key[i]; req_block[i*128 +: 128] = j_blk[i];
    end
  endtask

  task automatic new_job(input int i);
    pend[i] = 1'b1; j_enc[i] = 1'($urandom); j_kl[i] = 1'($urandom);
    j_key[i] = key_pool[$urandom_range(2, 0)];
    j_blk[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One complete job: grant, capture, response with optional backpressure, model update.
  task automatic serve_one(input int rsp_delay, input bit arm_all);
    int g, n, i0;
    bit exp_init;
    logic e_enc, e_kl;
    logic [255:0] e_key;
    logic [127:0] e_blk, exp_res;
    g = -1;
    for (int k = 1; k <= int'(N); k++) if (g < 0 && pend[(mlast + k) % int'(N)]) g = (mlast + k) % int'(N);
    if (g < 0) begin new_job(0); g = 0; end
    e_enc = j_enc[g]; e_kl = j_kl[g]; e_key = j_key[g]; e_blk = j_blk[g];
    exp_init = !CACHE || !mloaded || mkl != e_kl || mkey != eff(e_kl, e_key);
    exp_res  = core_fn(e_enc, e_kl, e_key, e_blk);
    drive(); #1;
    n = 0;
    while (req_ready == '0 && n < 200) begin tick(); n++; end
    chk("grant", 256'(req_ready), 256'(1) << g);
    i0 = init_cnt;
    tick();
    pend[g] = 1'b0;
    if (arm_all) for (int i = 0; i < int'(N); i++) if (!pend[i]) new_job(i);
    drive();
    chk("core_key", core_key, e_key);
    chk("core_ctl", {core_encdec, core_keylen, core_block}, {e_enc, e_kl, e_blk});
    rsp_ready = N'($urandom) & ~(N'(1) << g);
    if (rsp_delay == 0) rsp_ready[g] = 1'b1;
    n = 0;
    while (rsp_valid == '0 && n < 400) begin tick(); n++; end
    chk("rsp_valid", 256'(rsp_valid), 256'(1) << g);
    chk("rsp_result", 256'(rsp_result), 256'(exp_res));
    chk("init_count", 256'(init_cnt - i0), 256'(exp_init));
    chk("no_grant_in_resp", 256'(req_ready), 256'(0));
    for (int d = 0; d < rsp_delay; d++) begin
      tick();
      chk("rsp_hold", {rsp_valid, rsp_result}, {(N)'(1) << g, exp_res});
      chk("bp_ready", 256'(req_ready), 256'(0));
    end
    rsp_ready[g] = 1'b1;
    tick();
    chk("rsp_one_cycle", 256'(rsp_valid), 256'(0));
    chk("key_stable", {core_key, core_encdec}, {e_key, e_enc});
    rsp_ready = '0;
    mlast = g;
    if (exp_init) begin mloaded = 1'b1; mkl = e_kl; mkey = eff(e_kl, e_key); end
  endtask

  initial begin
    int c0, n;
    key_pool[0] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key_pool[1] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key_pool[2] = KAT_KEY;
    for (int i = 0; i < int'(N); i++) begin pend[i] = 1'b0; new_job(i); pend[i] = 1'b0; end
    rsp_ready = '0; reset_n = 1'b0; drive();
    mlast = int'(N) - 1; mloaded = 1'b0; mkl = 1'b0; mkey = '0;

    // Reset state
    tick(); tick();
    pend[1] = 1'b1; drive(); #1;
    chk("rst_outputs", {req_ready, rsp_valid, core_init, core_next}, '0);
    chk("rst_regs", {rsp_result, core_key[127:0]}, '0);
    reset_n = 1'b1; pend[1] = 1'b0; drive();
    tick();

    // Known-answer encrypt then decrypt on requester 0
    pend[0] = 1'b1; j_enc[0] = 1'b1; j_kl[0] = 1'b1; j_key[0] = KAT_KEY; j_blk[0] = KAT_PT;
    serve_one(1, 1'b0);
    pend[0] = 1'b1; j_enc[0] = 1'b0; j_blk[0] = KAT_CT;
    serve_one(0, 1'b0);
    chk("kat_decrypt", 256'(rsp_result), 256'(KAT_PT));

    // Round-robin with every requester always pending
    for (int i = 0; i < int'(N); i++) new_job(i);
    for (int r = 0; r < 6; r++) serve_one(r % 2, 1'b1);

    // Key cache: same 128-bit key twice (upper half differs), then a new key
    for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
    c0 = init_cnt;
    new_job(0); j_kl[0] = 1'b0; j_key[0] = {128'h1111, 128'hcafe_f00d}; serve_one(0, 1'b0);
    new_job(0); j_kl[0] = 1'b0; j_key[0] = {128'h2222, 128'hcafe_f00d}; serve_one(0, 1'b0);
    new_job(0); j_kl[0] = 1'b0; j_key[0] = {128'h2222, 128'hbeef};      serve_one(1, 1'b0);
    chk("cache_inits", 256'(init_cnt - c0), CACHE ? 256'd2 : 256'd3);

    // Backpressure on requester 1 while everyone else waits
    new_job(1); serve_one(10, 1'b1);

    // Core busy in idle: no grant, no pulses
    force_busy = 1'b1; drive(); #1;
    c0 = init_cnt + next_cnt;
    for (int i = 0; i < 5; i++) begin tick(); chk("busy_no_grant", 256'(req_ready), 256'(0)); end
    chk("busy_no_pulse", 256'(init_cnt + next_cnt - c0), 256'(0));
    force_busy = 1'b0;
    serve_one(0, 1'b0);

    // Reset during NEXT_WAIT drops the job
    for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
    lat_lo = 30; lat_hi = 30;
    new_job(2); drive(); #1;
    n = 0;
    while (req_ready == '0 && n < 200) begin tick(); n++; end
    c0 = next_cnt;
    tick(); pend[2] = 1'b0; drive();
    n = 0;
    while (next_cnt == c0 && n < 200) begin tick(); n++; end
    chk("reached_next", 256'(next_cnt - c0), 256'd1);
    tick(); tick();
    reset_n = 1'b0; new_job(0); new_job(2); drive();
    tick(); tick();
    chk("midop_rst", {req_ready, rsp_valid, core_init, core_next}, '0);
    chk("midop_rst_result", 256'(rsp_result), 256'(0));
    reset_n = 1'b1; lat_lo = 0; lat_hi = 4;
    mlast = int'(N) - 1; mloaded = 1'b0;
    serve_one(0, 1'b0);
    serve_one(2, 1'b0);

    // Random jobs
    for (int t = 0; t < 40; t++) begin
      lat_hi = $urandom_range(5, 0);
      for (int i = 0; i < int'(N); i++) if (!pend[i] && $urandom_range(1, 0) == 1) new_job(i);
      serve_one($urandom_range(3, 0), $urandom_range(3, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
